// File: rtl/inst_fetch_port.sv
// Instruction fetch port: a multi-cycle fetch from a preloadable word memory.
// A request (ce_i/pc_i) is accepted in IDLE, waits WAIT_CYCLES cycles in BUSY,
// then presents the word in RESP until the downstream stage takes it (hold_i=0).
// The memory is loaded through a separate write port that works in any state.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ce_i, pc_i        fetch request and byte address from the PC stage
//   flush_i           branch redirect, cancels the in-flight fetch
//   hold_i            downstream stall while a response is presented
//   ld_en_i/addr/data memory preload write port
//   inst_o            fetched word (0 on a misaligned fetch)
//   inst_valid_o      inst_o is valid this cycle
//   inst_addr_o       pc of the word on inst_o
//   addr_err_o        misaligned fetch, qualified by inst_valid_o
//   stallreq_o        hold the PC stage until the response is presented
module inst_fetch_port #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           pc_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  input  logic                  ld_en_i,
  input  logic [DEPTH_LOG2-1:0] ld_addr_i,
  input  logic [31:0]           ld_data_i,
  output logic [31:0]           inst_o,
  output logic                  inst_valid_o,
  output logic [31:0]           inst_addr_o,
  output logic                  addr_err_o,
  output logic                  stallreq_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [Depth];

  logic [31:0] rd_addr;
  logic [31:0] rd_word;
  logic        rd_misal;
  logic        load_resp;

  // Memory is not reset; a same-cycle write is seen only from the next cycle,
  // so a read taken on the write edge returns the old word.
  always_ff @(posedge clk) begin
    if (ld_en_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  // With WAIT_CYCLES=0 the read happens on the accept edge, before addr_q holds pc.
  always_comb begin
    rd_addr  = (state_q == StIdle) ? pc_i : addr_q;
    rd_word  = mem_q[rd_addr[DEPTH_LOG2+1:2]];
    rd_misal = |rd_addr[1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    valid_d     = valid_q;
    err_d       = err_q;
    load_resp   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ce_i && !flush_i) begin
          addr_d = pc_i;
          if (WAIT_CYCLES == 0) begin
            state_d   = StResp;
            load_resp = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      StBusy: begin
        if (flush_i || !ce_i) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d   = StResp;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (flush_i || !hold_i) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
        valid_d = 1'b0;
      end
    endcase

    if (load_resp) begin
      inst_d      = rd_misal ? 32'h0 : rd_word;
      inst_addr_d = rd_addr;
      valid_d     = 1'b1;
      err_d       = rd_misal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= 32'h0;
      inst_q      <= 32'h0;
      inst_addr_q <= 32'h0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // A flush hides the presented response in the same cycle.
  always_comb begin
    inst_o       = inst_q;
    inst_addr_o  = inst_addr_q;
    addr_err_o   = err_q;
    inst_valid_o = valid_q & ~flush_i;
    stallreq_o   = ce_i & (state_q != StResp);
  end

endmodule

// File: doc/inst_fetch_port.md
INST_FETCH_PORT -- requirements
Module: inst_fetch_port

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: instruction memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 0..15: number of wait states per fetch.
REQ-003 clk  in  1  clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 ce  in  1  fetch request enable from the PC stage; 1 = pc is valid.
REQ-006 pc  in  32  fetch byte address.
REQ-007 flush  in  1  branch redirect; cancels the in-flight fetch.
REQ-008 hold  in  1  downstream stall; IF/ID cannot accept an instruction.
REQ-009 ld_en  in  1  preload write enable.
REQ-010 ld_addr  in  DEPTH_LOG2  preload word index.
REQ-011 ld_data  in  32  preload word.
REQ-012 inst  out  32  fetched instruction.
REQ-013 inst_valid  out  1  inst holds a valid fetch result this cycle.
REQ-014 inst_addr  out  32  pc of the instruction on inst.
REQ-015 addr_err  out  1  misaligned-fetch flag; qualified by inst_valid.
REQ-016 stallreq  out  1  request to ctrl to hold the PC stage.

Function
REQ-017 The block shall implement the states IDLE, BUSY and RESP with a 4-bit wait counter cnt.
REQ-018 In IDLE with ce=1 and flush=0, the block shall latch pc into addr_q and go to BUSY with cnt=WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
REQ-019 In IDLE with ce=0, the block shall remain in IDLE.
REQ-020 In BUSY, cnt shall decrement each cycle, and the block shall go to RESP on the cycle in which cnt=0.
REQ-021 On entry to RESP, the block shall register inst=mem[addr_q[DEPTH_LOG2+1:2]], inst_addr=addr_q, inst_valid=1, and addr_err=(addr_q[1:0]!=0).
REQ-022 When addr_err=1, inst shall be 32'h0 (NOP).
REQ-023 Address bits above DEPTH_LOG2+1 shall be ignored, so fetch addresses wrap modulo the memory size.
REQ-024 Fetch latency from acceptance in IDLE to inst_valid=1 shall be WAIT_CYCLES+1 cycles.
REQ-025 In RESP with hold=1, the block shall remain in RESP with inst, inst_addr, addr_err and inst_valid unchanged.
REQ-026 In RESP with hold=0, the block shall return to IDLE, and inst_valid shall be 0 from the next cycle.
REQ-027 stallreq shall be combinational and equal ce & (state!=RESP), so the PC stage holds until the response is presented.
REQ-028 flush=1 in BUSY shall abort the fetch: return to IDLE with no inst_valid pulse.
REQ-029 flush=1 in RESP shall clear inst_valid in the same cycle (combinational mask) and force a return to IDLE, regardless of hold.
REQ-030 flush=1 in IDLE shall prevent acceptance that cycle.
REQ-031 ce=0 in BUSY shall abort the fetch to IDLE.
REQ-032 ld_en=1 shall write ld_data to mem[ld_addr] in any state.
REQ-033 A preload write to the same index on the cycle the read is taken (the BUSY->RESP or IDLE->RESP edge) shall return the old data.
REQ-034 Throughput shall be one instruction per WAIT_CYCLES+2 cycles with hold=0.

Reset
REQ-035 rst=1 shall force state=IDLE, cnt=0, inst=0, inst_addr=0, inst_valid=0 and addr_err=0 on the next edge, aborting any fetch in flight.
REQ-036 Memory contents shall not be affected by reset.
REQ-037 stallreq shall be 0 while in IDLE with ce=0.

Verification
REQ-038 WAIT_CYCLES=2; preload mem[0]=0x3C010001; ce=1, pc=0x0 accepted at T0 -> stallreq=1 at T0..T2; inst_valid=1, inst=0x3C010001, inst_addr=0 at T3; stallreq=0 at T3.
REQ-039 pc=0x6 -> inst_valid=1, addr_err=1, inst=0x0 after 3 cycles.
REQ-040 flush=1 at T1 of a fetch of pc=0x4 -> no inst_valid pulse, state IDLE at T2; a new pc=0x40 accepted at T2 returns mem[16] at T5.
REQ-041 hold=1 for 4 cycles during RESP -> inst and inst_valid stable for 5 cycles, stallreq=0 throughout.
REQ-042 DEPTH_LOG2=10; pc=0x1004 -> returns mem[1] (wrap-around).
REQ-043 rst=1 during BUSY -> inst_valid=0 and state IDLE next cycle; ld_en write to index 2 at the read edge of pc=0x8 -> old word returned.
